// File: rtl/adventure_pkg.sv
// Shared definitions for the adventure game: room encoding, button indices
// and the room-to-room move table. The sword FSM and LED driver use the same package.
package adventure_pkg;

    localparam int NUM_ROOMS = 7;
    localparam int NUM_DIRS  = 4;

    // Bit positions of the direction buttons inside a 4-bit button vector.
    localparam int DIR_N = 0;
    localparam int DIR_S = 1;
    localparam int DIR_E = 2;
    localparam int DIR_W = 3;

    typedef enum logic [2:0] {
        CAVE,
        TUNNEL,
        RIVER,
        SWORD_STASH,
        DRAGON_DEN,
        VICTORY_VAULT,
        GRAVEYARD
    } room_t;

    // Result of looking up a single direction press in the map.
    typedef struct packed {
        logic  legal;
        room_t dest;
    } hop_t;

    // Map walk for one one-hot direction press. Rooms without an exit in
    // that direction, plus the den and terminal rooms, report illegal.
    function automatic hop_t room_hop(input room_t cur, input logic [NUM_DIRS-1:0] dir);
        hop_t h;
        h.legal = 1'b0;
        h.dest  = cur;
        case (cur)
            CAVE: begin
                if (dir[DIR_E]) begin h.legal = 1'b1; h.dest = TUNNEL; end
            end
            TUNNEL: begin
                if (dir[DIR_W])      begin h.legal = 1'b1; h.dest = CAVE;  end
                else if (dir[DIR_S]) begin h.legal = 1'b1; h.dest = RIVER; end
            end
            RIVER: begin
                if (dir[DIR_N])      begin h.legal = 1'b1; h.dest = TUNNEL;      end
                else if (dir[DIR_W]) begin h.legal = 1'b1; h.dest = SWORD_STASH; end
                else if (dir[DIR_E]) begin h.legal = 1'b1; h.dest = DRAGON_DEN;  end
            end
            SWORD_STASH: begin
                if (dir[DIR_E]) begin h.legal = 1'b1; h.dest = RIVER; end
            end
            default: begin
                h.legal = 1'b0;
            end
        endcase
        return h;
    endfunction

    // True when more than one bit of the vector is set.
    function automatic logic multi_hot(input logic [NUM_DIRS-1:0] vec);
        return |(vec & (vec - NUM_DIRS'(1)));
    endfunction

    // One-hot LED image of a room; bit order follows room_t.
    function automatic logic [NUM_ROOMS-1:0] room_onehot(input room_t r);
        return NUM_ROOMS'(1) << r;
    endfunction

endpackage

// File: rtl/adventure_room_ctrl_press_detect.sv
// Rising-edge detector for the four direction buttons. History resets to 1
// so a button held through reset needs a fresh press before it counts.
module press_detect
    import adventure_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_DIRS-1:0] btn,
    output logic [NUM_DIRS-1:0] press,
    output logic                multi
);

    logic [NUM_DIRS-1:0] prev;
    logic [NUM_DIRS-1:0] rise;

    assign rise = btn & ~prev;

    // Register button history and the detected presses for the room logic.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            prev  <= '1;
            press <= '0;
            multi <= 1'b0;
        end else begin
            prev  <= btn;
            press <= rise;
            multi <= multi_hot(rise);
        end
    end

endmodule

// File: rtl/adventure_room_ctrl.sv
// Room-sequencing controller: walks the map on direction presses, resolves
// the dragon encounter from the sword flag and counts legal moves.
module adventure_room_ctrl
    import adventure_pkg::*;
#(
    parameter int          MOVE_W     = 8,
    parameter int unsigned MOVE_LIMIT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 n,
    input  logic                 s,
    input  logic                 e,
    input  logic                 w,
    input  logic                 v,
    output logic [NUM_ROOMS-1:0] room,
    output logic                 sw,
    output logic                 win,
    output logic                 dead,
    output logic                 bump,
    output logic [MOVE_W-1:0]    moves
);

    logic [NUM_DIRS-1:0] btn;
    logic [NUM_DIRS-1:0] press;
    logic                multi;

    room_t               state;
    room_t               state_next;
    logic                bump_next;
    logic                advance;
    logic [MOVE_W-1:0]   moves_inc;
    logic                limit_hit;
    hop_t                hop;

    always_comb begin
        btn         = '0;
        btn[DIR_N]  = n;
        btn[DIR_S]  = s;
        btn[DIR_E]  = e;
        btn[DIR_W]  = w;
    end

    press_detect u_press_detect (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .press (press),
        .multi (multi)
    );

    // Saturating next count, and whether that count exhausts the move budget.
    assign moves_inc = (moves == '1) ? moves : moves + MOVE_W'(1);
    assign limit_hit = (MOVE_LIMIT != 0) && (32'(moves_inc) == MOVE_LIMIT);
    assign hop       = room_hop(state, press);

    // Next-room, bump and move-advance decision for the current press vector.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        bump_next  = 1'b0;
        advance    = 1'b0;
        case (state)
            DRAGON_DEN: begin
                state_next = v ? VICTORY_VAULT : GRAVEYARD;
            end
            VICTORY_VAULT, GRAVEYARD: begin
                state_next = state;
            end
            default: begin
                if (multi) begin
                    bump_next = 1'b1;
                end else if (press != '0) begin
                    if (hop.legal) begin
                        advance = 1'b1;
                        // The den is exempt so the encounter always resolves.
                        if (limit_hit && hop.dest != DRAGON_DEN) begin
                            state_next = GRAVEYARD;
                        end else begin
                            state_next = hop.dest;
                        end
                    end else begin
                        bump_next = 1'b1;
                    end
                end
            end
        endcase
    end

    // Room register, bump pulse and move counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CAVE;
            bump  <= 1'b0;
            moves <= '0;
        end else begin
            state <= state_next;
            bump  <= bump_next;
            if (advance) begin
                moves <= moves_inc;
            end
        end
    end

    assign room = room_onehot(state);
    assign sw   = (state == SWORD_STASH);
    assign win  = (state == VICTORY_VAULT);
    assign dead = (state == GRAVEYARD);

endmodule

// File: tb/tb_adventure_room_ctrl.sv
// Directed bench for adventure_room_ctrl: four instances share clock and reset
// (default build, MOVE_LIMIT=4, MOVE_LIMIT=3, and a 2-bit counter with no limit).
module tb_adventure_room_ctrl;
    import adventure_pkg::*;

    localparam logic [3:0] B_N = 4'b0001;
    localparam logic [3:0] B_S = 4'b0010;
    localparam logic [3:0] B_E = 4'b0100;
    localparam logic [3:0] B_W = 4'b1000;

    localparam logic [6:0] R_CAVE   = 7'b0000001;
    localparam logic [6:0] R_TUNNEL = 7'b0000010;
    localparam logic [6:0] R_RIVER  = 7'b0000100;
    localparam logic [6:0] R_STASH  = 7'b0001000;
    localparam logic [6:0] R_DEN    = 7'b0010000;
    localparam logic [6:0] R_VAULT  = 7'b0100000;
    localparam logic [6:0] R_GRAVE  = 7'b1000000;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn [4];
    logic       v   [4];
    logic [6:0] room [4];
    logic       sw   [4];
    logic       win  [4];
    logic       dead [4];
    logic       bump [4];
    logic [7:0] moves0, moves1, moves2;
    logic [1:0] moves3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adventure_room_ctrl dut (
        .clk(clk), .reset(reset),
        .n(btn[0][DIR_N]), .s(btn[0][DIR_S]), .e(btn[0][DIR_E]), .w(btn[0][DIR_W]),
        .v(v[0]), .room(room[0]), .sw(sw[0]), .win(win[0]), .dead(dead[0]),
        .bump(bump[0]), .moves(moves0)
    );

    adventure_room_ctrl #(.MOVE_W(8), .MOVE_LIMIT(4)) dut_l4 (
        .clk(clk), .reset(reset),
        .n(btn[1][DIR_N]), .s(btn[1][DIR_S]), .e(btn[1][DIR_E]), .w(btn[1][DIR_W]),
        .v(v[1]), .room(room[1]), .sw(sw[1]), .win(win[1]), .dead(dead[1]),
        .bump(bump[1]), .moves(moves1)
    );

    adventure_room_ctrl #(.MOVE_W(8), .MOVE_LIMIT(3)) dut_l3 (
        .clk(clk), .reset(reset),
        .n(btn[2][DIR_N]), .s(btn[2][DIR_S]), .e(btn[2][DIR_E]), .w(btn[2][DIR_W]),
        .v(v[2]), .room(room[2]), .sw(sw[2]), .win(win[2]), .dead(dead[2]),
        .bump(bump[2]), .moves(moves2)
    );

    adventure_room_ctrl #(.MOVE_W(2), .MOVE_LIMIT(0)) dut_sat (
        .clk(clk), .reset(reset),
        .n(btn[3][DIR_N]), .s(btn[3][DIR_S]), .e(btn[3][DIR_E]), .w(btn[3][DIR_W]),
        .v(v[3]), .room(room[3]), .sw(sw[3]), .win(win[3]), .dead(dead[3]),
        .bump(bump[3]), .moves(moves3)
    );

    // Sword FSM model: latches sw one cycle after the stash is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      v[0] <= 1'b0;
        else if (sw[0]) v[0] <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Press lands at the next edge; room/bump update one edge later.
    task automatic press(input int idx, input logic [3:0] b);
        btn[idx] = b;
        tick(2);
    endtask

    task automatic release_btn(input int idx);
        btn[idx] = 4'b0000;
        tick(1);
    endtask

    // Synchronous-looking release of an asynchronously asserted reset.
    task automatic end_reset();
        @(negedge clk);
        reset = 1'b0;
        tick(1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) btn[i] = 4'b0000;
        v[1] = 1'b0;
        v[2] = 1'b1;
        v[3] = 1'b0;
        reset = 1'b1;
        tick(2);
        chk("reset_room", 32'(room[0]), 32'(R_CAVE));
        chk("reset_flags", {sw[0], win[0], dead[0], bump[0]}, 4'b0000);
        chk("reset_moves", 32'(moves0), 0);
        end_reset();

        // Winning path: E S W E E with the sword picked up on the way.
        press(0, B_E); chk("a_tunnel", 32'(room[0]), 32'(R_TUNNEL)); release_btn(0);
        press(0, B_S); chk("a_river", 32'(room[0]), 32'(R_RIVER)); release_btn(0);
        press(0, B_W); chk("a_stash", 32'(room[0]), 32'(R_STASH));
        chk("a_sw", 32'(sw[0]), 1);
        release_btn(0);
        press(0, B_E); chk("a_river2", 32'(room[0]), 32'(R_RIVER)); release_btn(0);
        press(0, B_E); chk("a_den", 32'(room[0]), 32'(R_DEN));
        chk("a_den_moves", 32'(moves0), 5);
        release_btn(0);
        chk("a_vault", 32'(room[0]), 32'(R_VAULT));
        chk("a_win", {win[0], dead[0]}, 2'b10);
        chk("a_moves", 32'(moves0), 5);
        press(0, B_W);
        chk("a_vault_ignores", {room[0], bump[0]}, {R_VAULT, 1'b0});
        release_btn(0);

        // Asynchronous reset out of the vault.
        reset = 1'b1;
        #1;
        chk("rst_vault_room", 32'(room[0]), 32'(R_CAVE));
        chk("rst_vault_moves", 32'(moves0), 0);
        chk("rst_vault_flags", {sw[0], win[0], dead[0], bump[0]}, 4'b0000);
        end_reset();

        // Losing path: E S E without the sword.
        press(0, B_E); release_btn(0);
        press(0, B_S); release_btn(0);
        press(0, B_E); chk("b_den", 32'(room[0]), 32'(R_DEN)); release_btn(0);
        chk("b_grave", 32'(room[0]), 32'(R_GRAVE));
        chk("b_flags", {win[0], dead[0]}, 2'b01);
        chk("b_moves", 32'(moves0), 3);
        press(0, B_N);
        chk("b_grave_ignores", {room[0], bump[0]}, {R_GRAVE, 1'b0});
        release_btn(0);

        // Illegal and ambiguous presses in the cave.
        reset = 1'b1;
        end_reset();
        press(0, B_N);
        chk("c_bump", 32'(bump[0]), 1);
        chk("c_room", 32'(room[0]), 32'(R_CAVE));
        chk("c_moves", 32'(moves0), 0);
        release_btn(0);
        chk("c_bump_pulse", 32'(bump[0]), 0);
        press(0, B_N | B_E);
        chk("c_multi_bump", 32'(bump[0]), 1);
        chk("c_multi_room", 32'(room[0]), 32'(R_CAVE));
        release_btn(0);
        chk("c_multi_pulse", 32'(bump[0]), 0);

        // Asynchronous reset while in the den.
        press(0, B_E); release_btn(0);
        press(0, B_S); release_btn(0);
        press(0, B_E);
        chk("d_den", 32'(room[0]), 32'(R_DEN));
        reset = 1'b1;
        #1;
        chk("rst_den_room", 32'(room[0]), 32'(R_CAVE));
        chk("rst_den_moves", 32'(moves0), 0);
        btn[0] = 4'b0000;
        end_reset();

        // Button held through reset release must be pressed again.
        reset = 1'b1;
        btn[0] = B_E;
        end_reset();
        tick(3);
        chk("h_held_room", 32'(room[0]), 32'(R_CAVE));
        chk("h_held_bump", 32'(bump[0]), 0);
        release_btn(0);
        press(0, B_E);
        chk("h_repress", 32'(room[0]), 32'(R_TUNNEL));
        release_btn(0);

        // Move budget of 4: the 4th legal move diverts to the graveyard.
        reset = 1'b1;
        end_reset();
        press(1, B_E); release_btn(1);
        press(1, B_W); release_btn(1);
        press(1, B_E);
        chk("l4_third", 32'(room[1]), 32'(R_TUNNEL));
        release_btn(1);
        press(1, B_W);
        chk("l4_grave", 32'(room[1]), 32'(R_GRAVE));
        chk("l4_moves", 32'(moves1), 4);
        chk("l4_dead", 32'(dead[1]), 1);
        release_btn(1);

        // Move budget of 3 ends on the den: the encounter still resolves.
        press(2, B_E); release_btn(2);
        press(2, B_S); release_btn(2);
        press(2, B_E);
        chk("l3_den", 32'(room[2]), 32'(R_DEN));
        chk("l3_moves", 32'(moves2), 3);
        release_btn(2);
        chk("l3_vault", 32'(room[2]), 32'(R_VAULT));

        // 2-bit counter saturates at 3 after five legal moves.
        for (int i = 0; i < 5; i++) begin
            press(3, (i % 2 == 0) ? B_E : B_W);
            release_btn(3);
        end
        chk("sat_room", 32'(room[3]), 32'(R_TUNNEL));
        chk("sat_moves", 32'(moves3), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adventure_room_ctrl.md
# adventure_room_ctrl

Room-sequencing controller for the adventure game. It tracks the player's room from direction button presses and drives the sword-found signal into the sword FSM. It consumes that FSM's vorpal-sword flag to resolve the dragon encounter into a win or a death. It sits between the board's direction buttons and the sword FSM, and also drives the room/status LEDs and a move counter.

## Interface
Parameters:
- MOVE_W, 8, width of move counter
- MOVE_LIMIT, 32, legal-move budget before forced death; 0 disables the limit

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- n, s, e, w  in  1 each  raw direction buttons (level, already synchronized)
- v  in  1  vorpal sword held (from sword FSM)
- room  out  7  one-hot current room, bit order per room_t
- sw  out  1  sword found; high while in SWORD_STASH
- win  out  1  high while in VICTORY_VAULT
- dead  out  1  high while in GRAVEYARD
- bump  out  1  one-cycle pulse on an illegal or ambiguous press
- moves  out  MOVE_W  count of legal moves taken

## Operation
- A press is a 0->1 transition of a button between consecutive clocks. Only presses act; held buttons do nothing further.
- Exactly one press in a cycle means a move attempt. Two or more presses in the same cycle are ambiguous: no move, bump pulses.
- Room transitions (other directions from each room are illegal: no move, bump pulses, moves unchanged):
  - CAVE: E -> TUNNEL
  - TUNNEL: W -> CAVE, S -> RIVER
  - RIVER: N -> TUNNEL, W -> SWORD_STASH, E -> DRAGON_DEN
  - SWORD_STASH: E -> RIVER
  - DRAGON_DEN: ignores all buttons with no bump. On the next clock it goes to VICTORY_VAULT if v=1, otherwise to GRAVEYARD.
  - VICTORY_VAULT, GRAVEYARD: terminal. All buttons are ignored, no bump, until reset.
- Each legal move increments moves.
- moves saturates at 2^MOVE_W-1 and never wraps.
- Move limit, when MOVE_LIMIT≠0: a legal move that makes moves equal to MOVE_LIMIT goes to GRAVEYARD instead of its destination. Exception: if the destination is DRAGON_DEN, the move proceeds to DRAGON_DEN and resolves normally.
- sw, win and dead are pure decodes of the room state.
- room is always exactly one-hot.

## Timing
- Reset values:
  - room = CAVE (room[0]=1)
  - sw=0, win=0, dead=0, bump=0, moves=0
  - previous-button registers = 1, so a button held through reset must be released and pressed again before it counts
- Reset is asserted asynchronously. It may occur mid-game, including in DRAGON_DEN, and always returns the block to CAVE with the counter cleared.
- Press sampled high at edge k, after low at edge k-1: room, moves and bump update at edge k+1. Move latency is one cycle from the press being visible.
- sw rises the cycle SWORD_STASH is entered. The sword FSM latches it one cycle later. v is therefore stable long before DRAGON_DEN can be reached, since reaching it needs at least one move out of the stash.
- DRAGON_DEN lasts exactly one cycle. v is sampled on the edge that leaves DRAGON_DEN.
- A press arriving in the same cycle the room enters a terminal state or DRAGON_DEN is ignored.
- bump is high for exactly one cycle per offending press cycle.

## Structure
- Shared package adventure_pkg:
  - room_t enum, 7 values in order CAVE, TUNNEL, RIVER, SWORD_STASH, DRAGON_DEN, VICTORY_VAULT, GRAVEYARD
  - direction index constants DIR_N/S/E/W
  - The sword FSM and the LED driver import the same package.
- Sub-module press_detect: 4-bit rising-edge detector with reset-to-1 history. Outputs a 4-bit press vector and a multi-press flag.
- Top level holds the room register, next-room logic, saturating move counter with limit compare, and output decodes.

## Test plan
- Reset, then E, S, W, E, E presses with v driven by a sword FSM model -> rooms TUNNEL, RIVER, SWORD_STASH (sw=1), RIVER, DRAGON_DEN, then VICTORY_VAULT one cycle later; win=1, moves=5.
- Reset, E, S, E with v=0 -> DRAGON_DEN, then GRAVEYARD; dead=1, win=0, moves=3.
- In CAVE, press N -> bump pulses for 1 cycle, room stays CAVE, moves=0. Press N and E in the same cycle -> bump pulses, no move.
- Hold E through reset release -> no move. Release, then press E -> TUNNEL one cycle after the press.
- MOVE_LIMIT=4, alternate E/W from CAVE -> after the 4th legal move, room=GRAVEYARD and moves=4. Then with MOVE_LIMIT=3, E, S, E -> DRAGON_DEN is still entered and resolves on v.
- Assert reset while in DRAGON_DEN and in VICTORY_VAULT -> immediately room=CAVE, moves=0, all flags 0.
